multicycle_controller: RTL and testbench

Multi-cycle sequencer for the 32-bit register/ALU datapath. Fetches each instruction one byte per transfer from the byte-wide instruction memory, assembles it big-endian, and decodes opcodes 0–10. It then starts the execute stage, waits for completion, pulses the register-file write and advances the PC. Illegal opcodes and execute timeouts are trapped. It replaces the datapath's free-running PC/fetch logic with an explicit handshake-driven FSM.

---
 rtl/multicycle_controller_if.sv | 28 ++
 rtl/multicycle_controller.sv | 178 +++++++++++++++++
 tb/tb_multicycle_controller.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_controller_if.sv
// rtl/multicycle_controller_if.sv - instruction-memory, decode and execute handshake bundle
interface multicycle_controller_if;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_ack;
    logic [7:0]  imem_data;
    logic [4:0]  rf_read1;
    logic [4:0]  rf_read2;
    logic [4:0]  rf_waddr;
    logic [31:0] imm_ext;
    logic [2:0]  alu_op;
    logic        alu_src_imm;
    logic        exec_start;
    logic        exec_done;
    logic        rf_we;

    modport master (
        output imem_req, imem_addr, rf_read1, rf_read2, rf_waddr, imm_ext,
               alu_op, alu_src_imm, exec_start, rf_we,
        input  imem_ack, imem_data, exec_done
    );

    modport slave (
        input  imem_req, imem_addr, rf_read1, rf_read2, rf_waddr, imm_ext,
               alu_op, alu_src_imm, exec_start, rf_we,
        output imem_ack, imem_data, exec_done
    );
endinterface

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - fetch/decode/execute/writeback sequencer with illegal and timeout traps
module multicycle_controller #(
    parameter int unsigned PC_STEP      = 4,
    parameter int unsigned EXEC_TIMEOUT = 15
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    run_i,
    multicycle_controller_if.master bus,
    output logic [7:0]              pc_o,
    output logic                    halted_o,
    output logic                    illegal_o,
    output logic                    timeout_o
);
    typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, WB, TRAP} state_t;

    state_t      state_q;
    logic [7:0]  pc_q;
    logic [31:0] ir_q;
    logic [1:0]  byte_cnt_q;
    logic [7:0]  exec_cnt_q;
    logic        req_q, exec_start_q, rf_we_q;
    logic        halted_q, illegal_q, timeout_q;
    logic [4:0]  rd1_q, rd2_q, wa_q;
    logic [31:0] imm_q;
    logic [2:0]  alu_op_q;
    logic        src_imm_q;

    logic [31:0] ir_d;
    logic [5:0]  opc_d;
    logic        legal_d;
    logic [4:0]  rd2_d, wa_d;
    logic [2:0]  alu_op_d;
    logic        src_imm_d;

    // Word as it will look once the byte currently on the bus is captured.
    always_comb begin
        ir_d = ir_q;
        case (byte_cnt_q)
            2'd0: ir_d[31:24] = bus.imem_data;
            2'd1: ir_d[23:16] = bus.imem_data;
            2'd2: ir_d[15:8]  = bus.imem_data;
            default: ir_d[7:0] = bus.imem_data;
        endcase
    end

    always_comb begin
        opc_d     = ir_d[31:26];
        legal_d   = 1'b1;
        rd2_d     = ir_d[20:16];
        wa_d      = ir_d[15:11];
        alu_op_d  = 3'd0;
        src_imm_d = 1'b0;
        if (opc_d <= 6'd5) begin
            alu_op_d = opc_d[2:0];
        end else if (opc_d <= 6'd10) begin
            rd2_d     = 5'd0;
            wa_d      = ir_d[20:16];
            src_imm_d = 1'b1;
            case (opc_d)
                6'd6:    alu_op_d = 3'd0;
                6'd7:    alu_op_d = 3'd1;
                6'd8:    alu_op_d = 3'd2;
                6'd9:    alu_op_d = 3'd4;
                default: alu_op_d = 3'd5;
            endcase
        end else begin
            legal_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            pc_q         <= 8'd0;
            ir_q         <= 32'd0;
            byte_cnt_q   <= 2'd0;
            exec_cnt_q   <= 8'd0;
            req_q        <= 1'b0;
            exec_start_q <= 1'b0;
            rf_we_q      <= 1'b0;
            halted_q     <= 1'b1;
            illegal_q    <= 1'b0;
            timeout_q    <= 1'b0;
            rd1_q        <= 5'd0;
            rd2_q        <= 5'd0;
            wa_q         <= 5'd0;
            imm_q        <= 32'd0;
            alu_op_q     <= 3'd0;
            src_imm_q    <= 1'b0;
        end else begin
            exec_start_q <= 1'b0;
            rf_we_q      <= 1'b0;
            case (state_q)
                IDLE: begin
                    halted_q <= 1'b1;
                    if (run_i) begin
                        state_q    <= FETCH;
                        byte_cnt_q <= 2'd0;
                        req_q      <= 1'b1;
                        halted_q   <= 1'b0;
                    end
                end
                FETCH: begin
                    if (bus.imem_ack) begin
                        ir_q       <= ir_d;
                        byte_cnt_q <= byte_cnt_q + 2'd1;
                        if (byte_cnt_q == 2'd3) begin
                            req_q   <= 1'b0;
                            state_q <= DECODE;
                            // Decoded fields change only for legal words so they hold until the next decode.
                            if (legal_d) begin
                                rd1_q     <= ir_d[25:21];
                                rd2_q     <= rd2_d;
                                wa_q      <= wa_d;
                                imm_q     <= {{16{ir_d[15]}}, ir_d[15:0]};
                                alu_op_q  <= alu_op_d;
                                src_imm_q <= src_imm_d;
                            end
                        end
                    end
                end
                DECODE: begin
                    if (ir_q[31:26] > 6'd10) begin
                        state_q   <= TRAP;
                        illegal_q <= 1'b1;
                        halted_q  <= 1'b1;
                    end else begin
                        state_q      <= EXEC;
                        exec_start_q <= 1'b1;
                        exec_cnt_q   <= 8'd0;
                    end
                end
                EXEC: begin
                    if (bus.exec_done) begin
                        state_q <= WB;
                        rf_we_q <= 1'b1;
                    end else if (exec_cnt_q == 8'(EXEC_TIMEOUT - 1)) begin
                        state_q   <= TRAP;
                        timeout_q <= 1'b1;
                        halted_q  <= 1'b1;
                    end else begin
                        exec_cnt_q <= exec_cnt_q + 8'd1;
                    end
                end
                WB: begin
                    pc_q       <= pc_q + 8'(PC_STEP);
                    byte_cnt_q <= 2'd0;
                    if (run_i) begin
                        state_q <= FETCH;
                        req_q   <= 1'b1;
                    end else begin
                        state_q  <= IDLE;
                        halted_q <= 1'b1;
                    end
                end
                default: begin
                    halted_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.imem_req    = req_q;
    assign bus.imem_addr   = pc_q + {6'd0, byte_cnt_q};
    assign bus.rf_read1    = rd1_q;
    assign bus.rf_read2    = rd2_q;
    assign bus.rf_waddr    = wa_q;
    assign bus.imm_ext     = imm_q;
    assign bus.alu_op      = alu_op_q;
    assign bus.alu_src_imm = src_imm_q;
    assign bus.exec_start  = exec_start_q;
    assign bus.rf_we       = rf_we_q;
    assign pc_o            = pc_q;
    assign halted_o        = halted_q;
    assign illegal_o       = illegal_q;
    assign timeout_o       = timeout_q;
endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - scoreboard bench for multicycle_controller
module tb_multicycle_controller;
    logic       clk = 1'b0;
    logic       reset, run;
    logic [7:0] pc;
    logic       halted, illegal, timeout;

    multicycle_controller_if bus();

    multicycle_controller #(.PC_STEP(4), .EXEC_TIMEOUT(15)) dut (
        .clk(clk), .reset(reset), .run_i(run), .bus(bus.master),
        .pc_o(pc), .halted_o(halted), .illegal_o(illegal), .timeout_o(timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  pc;
        logic [4:0]  r1, r2, wa;
        logic [2:0]  op;
        logic        imm;
        logic [31:0] immx;
    } retire_t;

    retire_t    ret_q[$];
    logic [7:0] addr_q[$];
    logic [7:0] mem[256];
    int waits, wcnt, done_delay, ecnt, we_cnt;
    int n_checks, n_errors;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic retire_t ref_decode(input logic [7:0] p, input logic [31:0] ir);
        retire_t r;
        int opc;
        opc    = int'(ir[31:26]);
        r.pc   = p;
        r.r1   = ir[25:21];
        r.immx = {{16{ir[15]}}, ir[15:0]};
        if (opc <= 5) begin
            r.r2 = ir[20:16]; r.wa = ir[15:11]; r.op = 3'(opc); r.imm = 1'b0;
        end else begin
            r.r2 = 5'd0; r.wa = ir[20:16]; r.imm = 1'b1;
            case (opc)
                6: r.op = 3'd0;
                7: r.op = 3'd1;
                8: r.op = 3'd2;
                9: r.op = 3'd4;
                default: r.op = 3'd5;
            endcase
        end
        return r;
    endfunction

    task automatic put(input logic [7:0] a, input logic [31:0] w);
        mem[a] = w[31:24]; mem[8'(a + 1)] = w[23:16];
        mem[8'(a + 2)] = w[15:8]; mem[8'(a + 3)] = w[7:0];
    endtask

    task automatic exp_fetch(input logic [7:0] p);
        for (int i = 0; i < 4; i++) addr_q.push_back(8'(p + i));
    endtask

    task automatic exp_retire(input logic [7:0] p);
        logic [31:0] w;
        w = {mem[p], mem[8'(p + 1)], mem[8'(p + 2)], mem[8'(p + 3)]};
        ret_q.push_back(ref_decode(p, w));
    endtask

    // One cycle: sample at negedge, drive memory/execute responses, then score.
    task automatic tick;
        retire_t e;
        logic [7:0] a;
        @(negedge clk);
        if (reset) ecnt = 0;
        else if (bus.exec_start) ecnt = 1;
        else if (ecnt != 0 && ecnt < 1000) ecnt++;
        bus.exec_done = (done_delay != 0 && ecnt == done_delay);
        if (bus.imem_req && !reset) begin
            if (wcnt == waits) begin bus.imem_ack = 1'b1; wcnt = 0; end
            else begin bus.imem_ack = 1'b0; wcnt++; end
        end else begin
            bus.imem_ack = 1'b0; wcnt = 0;
        end
        bus.imem_data = bus.imem_ack ? mem[bus.imem_addr] : 8'($urandom);
        if (bus.imem_ack) begin
            check("fetch_pending", 32'(addr_q.size() != 0), 1);
            if (addr_q.size() != 0) begin
                a = addr_q.pop_front();
                check("imem_addr", bus.imem_addr, a);
            end
        end
        if (bus.rf_we || bus.exec_start)
            check("we_start_excl", 32'(bus.rf_we && bus.exec_start), 0);
        if (bus.rf_we) begin
            we_cnt++;
            check("retire_pending", 32'(ret_q.size() != 0), 1);
            if (ret_q.size() != 0) begin
                e = ret_q.pop_front();
                check("wb_pc", pc, e.pc);
                check("rf_read1", bus.rf_read1, e.r1);
                check("rf_read2", bus.rf_read2, e.r2);
                check("rf_waddr", bus.rf_waddr, e.wa);
                check("alu_op", bus.alu_op, e.op);
                check("alu_src_imm", bus.alu_src_imm, e.imm);
                check("imm_ext", bus.imm_ext, e.immx);
            end
        end
    endtask

    task automatic do_reset;
        reset = 1'b1; run = 1'b0;
        tick(); tick();
        reset = 1'b0;
    endtask

    initial begin
        int k, n, cyc, w0;
        n_checks = 0; n_errors = 0; we_cnt = 0; ecnt = 0; wcnt = 0;
        bus.imem_ack = 1'b0; bus.imem_data = 8'd0; bus.exec_done = 1'b0;
        for (int i = 0; i < 256; i += 4) put(8'(i), 32'h00221800);
        put(8'd4, 32'h2825FFFE);
        put(8'd8, 32'hB0000000);
        waits = 0; done_delay = 1;

        do_reset();
        tick();
        check("rst_halted", halted, 1);
        check("rst_pc", pc, 0);
        check("rst_req", bus.imem_req, 0);
        check("rst_addr", bus.imem_addr, 0);
        check("rst_we", bus.rf_we, 0);
        check("rst_start", bus.exec_start, 0);
        check("rst_illegal", illegal, 0);
        check("rst_timeout", timeout, 0);
        check("rst_alu_op", bus.alu_op, 0);

        // add, then slti with slow memory, then an illegal opcode at pc 8
        exp_fetch(0); exp_retire(0); exp_fetch(4); exp_retire(4); exp_fetch(8);
        run = 1'b1;
        for (cyc = 0; cyc < 20; ) begin
            tick(); cyc++;
            if (cyc == 1) begin
                check("c1_halted", halted, 0);
                check("c1_req", bus.imem_req, 1);
            end
            if (bus.rf_we) break;
        end
        check("cycles_to_we", cyc, 7);
        waits = 2;
        tick();
        check("pc_after_add", pc, 4);
        for (n = 0; n < 40 && bus.imem_req; n++) tick();
        check("slow_fetch_cycles", n, 12);
        waits = 0;
        for (k = 0; k < 40 && !bus.rf_we; k++) tick();
        check("slti_we_seen", 32'(k < 40), 1);
        tick();
        for (k = 0; k < 40 && !halted; k++) tick();
        check("trap_reached", 32'(k < 40), 1);
        check("trap_illegal", illegal, 1);
        check("trap_pc", pc, 8);
        check("trap_timeout", timeout, 0);
        check("trap_we_cnt", we_cnt, 2);
        n = 0;
        for (int i = 0; i < 10; i++) begin
            run = (i >= 3);
            tick();
            if (bus.imem_req || bus.rf_we || !halted) n++;
        end
        check("trap_stuck", n, 0);
        check("trap_pc_frozen", pc, 8);
        do_reset();
        tick();
        check("trap_cleared_illegal", illegal, 0);
        check("trap_cleared_pc", pc, 0);
        check("trap_cleared_halted", halted, 1);

        // exec_done withheld: trap after 15 EXEC cycles
        done_delay = 0; w0 = we_cnt;
        exp_fetch(0);
        run = 1'b1;
        for (k = 0; k < 40 && !bus.exec_start; k++) tick();
        for (n = 0; n < 40 && !halted; n++) tick();
        check("timeout_exec_cycles", n, 15);
        check("timeout_flag", timeout, 1);
        check("timeout_illegal", illegal, 0);
        check("timeout_pc", pc, 0);
        check("timeout_no_we", we_cnt, w0);
        do_reset();
        tick();
        check("timeout_cleared", timeout, 0);

        // exec_done on the 15th cycle wins; run dropped during EXEC finishes into IDLE
        done_delay = 15;
        exp_fetch(0); exp_retire(0);
        run = 1'b1;
        for (k = 0; k < 40 && !bus.exec_start; k++) tick();
        run = 1'b0;
        for (n = 0; n < 40 && !bus.rf_we; n++) tick();
        check("late_done_cycles", n, 15);
        tick();
        check("late_done_timeout", timeout, 0);
        check("late_done_idle", halted, 1);
        check("late_done_pc", pc, 4);
        tick();
        check("idle_no_req", bus.imem_req, 0);

        // pc wrap at 252, then reset in EXEC aborts the write
        put(8'd4, 32'h00221800); put(8'd8, 32'h00221800);
        do_reset();
        done_delay = 1; w0 = we_cnt;
        for (int p = 0; p < 256; p += 4) begin exp_fetch(8'(p)); exp_retire(8'(p)); end
        exp_fetch(0); exp_retire(0); exp_fetch(4);
        run = 1'b1;
        for (k = 0; k < 800 && we_cnt < w0 + 64; k++) tick();
        check("wrap_we_count", we_cnt, w0 + 64);
        check("wrap_wb_pc", pc, 252);
        tick();
        check("wrap_pc", pc, 0);
        check("wrap_addr", bus.imem_addr, 0);
        check("wrap_req", bus.imem_req, 1);
        for (k = 0; k < 40 && we_cnt < w0 + 65; k++) tick();
        done_delay = 0;
        for (k = 0; k < 40 && !bus.exec_start; k++) tick();
        check("abort_exec_seen", bus.exec_start, 1);
        tick();
        reset = 1'b1; run = 1'b0;
        tick();
        check("abort_no_we", bus.rf_we, 0);
        check("abort_pc", pc, 0);
        check("abort_halted", halted, 1);
        reset = 1'b0;
        tick(); tick();
        check("abort_we_count", we_cnt, w0 + 65);
        check("abort_ret_q_empty", ret_q.size(), 0);
        check("abort_addr_q_empty", addr_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
